// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the writeback-port arbiter.
// Register-zero alias, datapath width and arbiter state encoding.
package pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle around the register-file write port arbiter.
// slave is the arbiter side, master is the pipeline/unit/regfile side.
interface wb_port_arbiter_if;
    import pipe_pkg::*;

    logic              wb_reg_write;
    logic              wb_m2r;
    logic [4:0]        wb_target;
    logic [DATA_W-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;

    logic              lu_valid;
    logic              lu_ready;
    logic [4:0]        lu_target;
    logic [DATA_W-1:0] lu_result;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              stall_req;
    logic              pend_valid;
    logic [4:0]        pend_target;

    modport slave (
        input  wb_reg_write, wb_m2r, wb_target,
        input  wb_address, wb_data,
        input  lu_valid, lu_target, lu_result,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req, pend_valid, pend_target
    );

    modport master (
        output wb_reg_write, wb_m2r, wb_target,
        output wb_address, wb_data,
        output lu_valid, lu_target, lu_result,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req, pend_valid, pend_target
    );

endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between MEM/WB and the long-latency unit.
// Pipeline wins; a parked result drains into free slots or forces a bubble.
module wb_port_arbiter
    import pipe_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam logic [2:0] LIM_M1 = 3'(STARVE_LIMIT - 1);

    arb_state_t        state;
    logic [2:0]        cnt;
    logic [4:0]        hold_target;
    logic [DATA_W-1:0] hold_data;

    logic              wb_we_eff;
    logic [DATA_W-1:0] wb_wdata;
    logic              pend;
    logic              drain;
    logic              kill;
    logic              capture;

    assign wb_we_eff = bus.wb_reg_write && (bus.wb_target != REG_ZERO);
    assign wb_wdata  = bus.wb_m2r ? bus.wb_data : bus.wb_address;
    assign pend      = (state != IDLE);
    assign drain     = pend && !wb_we_eff;
    assign kill      = pend && wb_we_eff && (bus.wb_target == hold_target);
    assign capture   = (state == IDLE) && bus.lu_valid
                     && (bus.lu_target != REG_ZERO);

    assign bus.lu_ready    = rst && (state == IDLE);
    assign bus.stall_req   = (state == FORCE);
    assign bus.pend_valid  = pend;
    assign bus.pend_target = pend ? hold_target : REG_ZERO;

    // Port mux: pipeline write first, then the parked result; quiet in reset.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = REG_ZERO;
        bus.rf_wdata = '0;
        if (rst) begin
            if (wb_we_eff) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.wb_target;
                bus.rf_wdata = wb_wdata;
            end else if (pend) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = hold_target;
                bus.rf_wdata = hold_data;
            end
        end
    end

    // Hold register: loaded on a handshake with a non-zero target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_target <= REG_ZERO;
            hold_data   <= '0;
        end else if (capture) begin
            hold_target <= bus.lu_target;
            hold_data   <= bus.lu_result;
        end
    end

    // State and starvation counter: count blocked HOLD cycles, then force.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (capture) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (drain || kill) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt == LIM_M1) begin
                            state <= FORCE;
                        end
                    end
                end
                FORCE: begin
                    if (drain || kill) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the pipeline writeback stage (MEM/WB outputs) and a multi-cycle long-latency unit (mult/div) that finishes out of band. Pipeline writes always win. A finished long-latency result is parked in a one-entry hold register and drains into the next free writeback slot. If the port stays busy for too long, the block requests a pipeline bubble to force the drain. It sits between the MEM/WB register, the long-latency unit and the register file, and exports the pending target to the hazard unit.

## Interface
- STARVE_LIMIT, 4: consecutive blocked cycles in HOLD before a bubble is requested; legal range 1..7.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_reg_write  in  1  MEM/WB Reg_Write.
- wb_m2r  in  1  MEM/WB M2R; 1 selects wb_data, 0 selects wb_address.
- wb_target  in  5  MEM/WB destination register.
- wb_address  in  32  ALU result from MEM/WB.
- wb_data  in  32  memory read data from MEM/WB.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  hold register can accept a result.
- lu_target  in  5  long-latency destination register.
- lu_result  in  32  long-latency result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- stall_req  out  1  asks pipeline control to inject one WB bubble; held until the result drains.
- pend_valid  out  1  hold register occupied.
- pend_target  out  5  target of the held result; 0 when empty.

## Operation
- Effective pipeline write: wb_we_eff = wb_reg_write && (wb_target != 0). Pipeline write data = wb_m2r ? wb_data : wb_address.
- Port mux (combinational):
  - If wb_we_eff: the rf port carries the pipeline write.
  - Else if pend_valid: the rf port carries the hold contents, and the hold clears at the next edge (drain).
  - Else: rf_we = 0.
- lu_ready = (state == IDLE). A handshake (lu_valid && lu_ready) at the edge captures lu_target/lu_result.
  - If lu_target == 0, the result is discarded and the state stays IDLE.
- WAW kill: if pend_valid && wb_we_eff && wb_target == pend_target, the held result is discarded at the edge.
  - The pipeline write is younger. Issue logic guarantees no older write to the same target is in flight once lu_valid rises.
- FSM:
  - IDLE -> HOLD on capture; cnt <= 0.
  - HOLD -> IDLE on drain or kill. Otherwise cnt <= cnt+1; when cnt == STARVE_LIMIT-1 the next state is FORCE.
  - FORCE -> IDLE on drain or kill; otherwise stay.
- stall_req = (state == FORCE).
- pend_valid = (state != IDLE).
- Counter width 3 bits; counts only blocked cycles in HOLD; cleared on entry to HOLD and IDLE.

## Timing
- Reset (rst low, asynchronous):
  - state IDLE, hold register and cnt cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - lu_ready=0, stall_req=0, pend_valid=0, pend_target=0.
  - After release, lu_ready=1 in the first cycle.
- Pipeline write: zero latency; the rf port follows the MEM/WB outputs in the same cycle.
- Long-latency result: earliest register-file write is 1 cycle after capture; worst case is STARVE_LIMIT blocked cycles plus the stall round trip.
- Back-to-back results: after a drain the state returns to IDLE, so lu_ready rises one cycle after the drain cycle. Minimum spacing between captures is 2 cycles.
- Drain and kill in the same cycle are impossible: a drain requires wb_we_eff=0.
- A kill in FORCE drops stall_req on the next cycle.
- Reset mid-HOLD/FORCE loses the held result and negates stall_req immediately.
- A pipeline write to r0 never blocks the hold register.

## Structure
- Shared package pipe_pkg holds:
  - REG_ZERO (5'd0) and DATA_W (32);
  - the state enum {IDLE, HOLD, FORCE}, 2-bit encoding.
- Single module with no sub-modules. The hold register and counter are inline.

## Test plan
- Reset mid-FORCE: assert rst low while stall_req=1 -> all outputs 0 immediately, lu_ready=1 one cycle after release.
- Idle drain: capture lu_target=5, lu_result=0xDEADBEEF with wb_reg_write=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; lu_ready returns 1 the cycle after.
- Priority plus starvation, STARVE_LIMIT=4: hold target 7, wb_reg_write=1 to target 3 every cycle -> rf port shows target 3 each cycle; stall_req=1 after 4 blocked cycles; on the bubble cycle rf_waddr=7; stall_req=0 next cycle.
- WAW kill: hold target 9, pipeline writes target 9 with wb_m2r=1, wb_data=0x12 -> rf_wdata=0x12; pend_valid=0 next cycle; target 9 is never written with the held value.
- r0 handling: lu_target=0 -> no capture, pend_valid stays 0. Pipeline write to r0 while holding target 4 -> rf_we=1, rf_waddr=4 (drain).
